// File: rtl/ula_iter_if.sv
// Request/response bundle between an ALU client and ula_iter.
// The client drives operation and operands; the ALU returns result, flags and status.
interface ula_iter_if;
    logic        start;
    logic [3:0]  ALUControl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;

    modport master (
        output start, ALUControl, a, b,
        input  result, zero, busy, done
    );

    modport slave (
        input  start, ALUControl, a, b,
        output result, zero, busy, done
    );
endinterface

// File: rtl/ula_iter.sv
// 32-bit ALU with single-cycle logic/arithmetic ops and bit-serial shifts.
// A three-state FSM (IDLE/SHIFT/DONE) sequences each operation and pulses done once.
module ula_iter (
    input  logic      clk,
    input  logic      rst,
    ula_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [31:0] shreg_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;
    logic        zero_q;
    logic        busy_q;
    logic        done_q;

    logic        is_shift;
    logic [4:0]  amt;
    logic [31:0] alu_d;
    logic [31:0] shreg_d;

    assign amt      = bus.b[4:0];
    assign is_shift = (bus.ALUControl == OP_SLL) || (bus.ALUControl == OP_SRL) ||
                      (bus.ALUControl == OP_SRA);

    // Shift codes yield a unchanged here: only reached with a zero shift amount.
    always_comb begin
        alu_d = bus.a + bus.b;
        case (bus.ALUControl)
            OP_ADD:  alu_d = bus.a + bus.b;
            OP_SUB:  alu_d = bus.a - bus.b;
            OP_AND:  alu_d = bus.a & bus.b;
            OP_OR:   alu_d = bus.a | bus.b;
            OP_XOR:  alu_d = bus.a ^ bus.b;
            OP_NOR:  alu_d = ~(bus.a | bus.b);
            OP_SLT:  alu_d = ($signed(bus.a) < $signed(bus.b)) ? 32'd1 : 32'd0;
            OP_SLTU: alu_d = (bus.a < bus.b) ? 32'd1 : 32'd0;
            OP_SLL, OP_SRL, OP_SRA: alu_d = bus.a;
            default: alu_d = bus.a + bus.b;
        endcase
    end

    // One-bit step of the captured shift operation.
    always_comb begin
        shreg_d = {shreg_q[31], shreg_q[31:1]};
        case (op_q)
            OP_SLL:  shreg_d = {shreg_q[30:0], 1'b0};
            OP_SRL:  shreg_d = {1'b0, shreg_q[31:1]};
            default: shreg_d = {shreg_q[31], shreg_q[31:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            shreg_q  <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.ALUControl;
                        busy_q <= 1'b1;
                        if (is_shift && (amt != 5'd0)) begin
                            shreg_q <= bus.a;
                            cnt_q   <= amt;
                            state_q <= SHIFT;
                        end else begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == 32'd0);
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_q <= shreg_d;
                        zero_q   <= (shreg_d == 32'd0);
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_ula_iter.sv
// Directed self-checking bench for ula_iter: expected results are queued at issue
// time and compared when done pulses, along with latency and busy duration.
module tb_ula_iter;
    logic clk;
    logic rst;

    ula_iter_if bus_if ();

    ula_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        zero;
        int          lat;
    } sb_t;

    sb_t sb[$];
    int  n_eval = 0;
    int  n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            4'd5:    return ~(x | y);
            4'd6:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd7:    return (x < y) ? 32'd1 : 32'd0;
            4'd8:    return x << y[4:0];
            4'd9:    return x >> y[4:0];
            4'd10:   return 32'($signed(x) >>> y[4:0]);
            default: return x + y;
        endcase
    endfunction

    // Issue one op, optionally re-pulse start (ADD) at sample index repulse_at,
    // then wait (bounded) for done and score it against the queued expectation.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int repulse_at);
        sb_t it;
        sb_t ex;
        int  lat;
        int  busy_cnt;
        int  extra_done;
        bit  got;
        it.tag  = tag;
        it.res  = ref_alu(op, av, bv);
        it.zero = (it.res == 32'd0);
        it.lat  = ((op inside {4'd8, 4'd9, 4'd10}) && (bv[4:0] != 5'd0)) ? 1 + int'(bv[4:0]) : 1;
        sb.push_back(it);

        bus_if.start = 1'b1; bus_if.ALUControl = op; bus_if.a = av; bus_if.b = bv;
        tick();
        bus_if.start = 1'b0;
        bus_if.ALUControl = 4'($urandom); bus_if.a = $urandom; bus_if.b = $urandom;

        lat = 1; busy_cnt = 0; got = 1'b0;
        while (lat <= 40) begin
            if (bus_if.busy) busy_cnt++;
            if (lat == repulse_at) begin
                bus_if.start = 1'b1; bus_if.ALUControl = 4'd0;
                bus_if.a = 32'd1; bus_if.b = 32'd2;
            end
            if (bus_if.done) begin
                got = 1'b1;
                break;
            end
            tick();
            bus_if.start = 1'b0;
            lat++;
        end

        ex = sb.pop_front();
        chk({ex.tag, " done seen"}, 32'(got), 32'd1);
        chk({ex.tag, " latency"}, 32'(lat), 32'(ex.lat));
        chk({ex.tag, " busy cycles"}, 32'(busy_cnt), 32'(ex.lat));
        chk({ex.tag, " result"}, bus_if.result, ex.res);
        chk({ex.tag, " zero"}, 32'(bus_if.zero), 32'(ex.zero));

        tick();
        bus_if.start = 1'b0;
        chk({ex.tag, " busy after"}, 32'(bus_if.busy), 32'd0);
        extra_done = bus_if.done ? 1 : 0;
        tick(); if (bus_if.done) extra_done++;
        tick(); if (bus_if.done) extra_done++;
        chk({ex.tag, " extra done"}, 32'(extra_done), 32'd0);
        chk({ex.tag, " result held"}, bus_if.result, ex.res);
        $display("op %s: a=%h b=%h result=%h zero=%0b latency=%0d", ex.tag, av, bv,
                 bus_if.result, bus_if.zero, lat);
    endtask

    initial begin
        int dcount;
        rst = 1'b1;
        bus_if.start = 1'b0; bus_if.ALUControl = 4'd0; bus_if.a = 32'd0; bus_if.b = 32'd0;
        tick(); tick();
        chk("reset result", bus_if.result, 32'd0);
        chk("reset zero", 32'(bus_if.zero), 32'd1);
        chk("reset busy", 32'(bus_if.busy), 32'd0);
        chk("reset done", 32'(bus_if.done), 32'd0);

        // Reset wins over start.
        bus_if.start = 1'b1; bus_if.ALUControl = 4'd0; bus_if.a = 32'd5; bus_if.b = 32'd6;
        tick();
        bus_if.start = 1'b0;
        chk("rst over start busy", 32'(bus_if.busy), 32'd0);
        chk("rst over start result", bus_if.result, 32'd0);
        rst = 1'b0;
        tick();

        run_op("ADD wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("SLT", 4'd6, 32'hFFFF_FFFE, 32'd1, 0);
        run_op("SLTU", 4'd7, 32'hFFFF_FFFE, 32'd1, 0);
        chk("SLTU literal result", bus_if.result, 32'd0);
        run_op("SRA 31", 4'd10, 32'h8000_0000, 32'd31, 0);
        chk("SRA 31 literal", bus_if.result, 32'hFFFF_FFFF);
        run_op("SLL amt0", 4'd8, 32'd1, 32'h0000_0020, 0);
        chk("SLL amt0 literal", bus_if.result, 32'd1);
        run_op("SRL repulse", 4'd9, 32'h0000_00F0, 32'd4, 2);
        chk("SRL repulse literal", bus_if.result, 32'h0000_000F);
        run_op("SUB", 4'd1, 32'd5, 32'd7, 0);
        run_op("AND", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run_op("OR", 4'd3, 32'hA000_0001, 32'h0500_0010, 0);
        run_op("XOR", 4'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        run_op("NOR", 4'd5, 32'h0F0F_0F0F, 32'h00FF_00FF, 0);
        run_op("SLT pos", 4'd6, 32'd3, 32'hFFFF_FFFF, 0);
        run_op("SLTU big", 4'd7, 32'd3, 32'hFFFF_FFFF, 0);
        run_op("code 1011", 4'd11, 32'd40, 32'd2, 0);
        run_op("code 1111", 4'd15, 32'hFFFF_FFF0, 32'h10, 0);
        run_op("SRL 31", 4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("SLL 1", 4'd8, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("SRA pos", 4'd10, 32'h7FFF_FFFF, 32'd4, 0);
        run_op("SLL to zero", 4'd8, 32'h0000_0100, 32'd24, 0);
        run_op("ADD repulse in DONE", 4'd0, 32'd100, 32'd23, 1);

        // Back-to-back: start in the IDLE cycle right after DONE.
        bus_if.start = 1'b1; bus_if.ALUControl = 4'd0; bus_if.a = 32'd1; bus_if.b = 32'd2;
        tick();
        bus_if.start = 1'b0;
        chk("b2b first done", 32'(bus_if.done), 32'd1);
        chk("b2b first result", bus_if.result, 32'd3);
        tick();
        bus_if.start = 1'b1; bus_if.ALUControl = 4'd4; bus_if.a = 32'd6; bus_if.b = 32'd3;
        tick();
        bus_if.start = 1'b0;
        chk("b2b second done", 32'(bus_if.done), 32'd1);
        chk("b2b second result", bus_if.result, 32'd5);
        $display("op b2b: ADD 1+2 then XOR 6^3 result=%h", bus_if.result);
        tick(); tick();

        // Reset during SHIFT aborts the op.
        bus_if.start = 1'b1; bus_if.ALUControl = 4'd8; bus_if.a = 32'd1; bus_if.b = 32'd10;
        tick();
        bus_if.start = 1'b0;
        tick(); tick();
        chk("pre-abort busy", 32'(bus_if.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort result", bus_if.result, 32'd0);
        chk("abort busy", 32'(bus_if.busy), 32'd0);
        chk("abort zero", 32'(bus_if.zero), 32'd1);
        dcount = bus_if.done ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_if.done) dcount++;
        end
        chk("abort no done", 32'(dcount), 32'd0);
        $display("op abort: SLL 1<<10 reset mid-shift result=%h busy=%0b", bus_if.result,
                 bus_if.busy);
        run_op("OR after rst", 4'd3, 32'd3, 32'd4, 0);
        chk("OR after rst literal", bus_if.result, 32'd7);

        // Reset during DONE suppresses the remaining pulse and clears result.
        bus_if.start = 1'b1; bus_if.ALUControl = 4'd0; bus_if.a = 32'd1; bus_if.b = 32'd1;
        tick();
        bus_if.start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst in DONE done", 32'(bus_if.done), 32'd0);
        chk("rst in DONE result", bus_if.result, 32'd0);
        $display("op rst-in-DONE: result=%h done=%0b", bus_if.result, bus_if.done);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
